vj_detection_collector: RTL

Consumer end of the Viola-Jones classifier pipeline's detection output.
- Captures each accepted window (top-left coordinate, pyramid level, final stage accumulator).
- Rescales the coordinate and window size to original-image pixels using a per-pyramid-level Q8 scale factor.
- Buffers results in a first-word-fall-through FIFO.
- Serves results to a host reader over a valid/ready interface, with per-frame bookkeeping.

---
 rtl/vj_collector_pkg.sv | 28 ++
 rtl/vj_det_fifo.sv | 51 +++++
 rtl/vj_detection_collector.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vj_collector_pkg.sv
// Shared types and constants for the Viola-Jones detection collector:
// pyramid scale table, collector state encoding and the buffered entry layout.
package vj_collector_pkg;

  localparam int NUM_PYRAMID = 10;
  localparam int DET_COORD_W = 16;

  // Q8 scale per pyramid level: round(256 * 1.25^level).
  localparam logic [NUM_PYRAMID-1:0][15:0] SCALE_Q8 = {
    16'd1907, 16'd1526, 16'd1221, 16'd977, 16'd781,
    16'd625,  16'd500,  16'd400,  16'd320, 16'd256
  };

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [DET_COORD_W-1:0] x;
    logic [DET_COORD_W-1:0] y;
    logic [DET_COORD_W-1:0] size;
    logic signed [31:0]     score;
  } det_entry_t;

endpackage

// File: rtl/vj_det_fifo.sv
// First-word-fall-through FIFO of detection entries; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module vj_det_fifo
  import vj_collector_pkg::*;
#(
  parameter int  DEPTH = 64,
  parameter type T     = det_entry_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic           do_pop;
  logic           do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage array has no reset; emptiness is carried by the pointers alone.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vj_detection_collector.sv
// Collects accepted classifier windows, rescales them to source-image pixels
// and serves them to a host through a FWFT FIFO with per-frame bookkeeping.
module vj_detection_collector
  import vj_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int COORD_W    = 16,
  parameter int FRAC_BITS  = 8,
  parameter int WIN_SIZE   = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic                     det_valid,
  input  logic [1:0][31:0]         det_top_left,
  input  logic [3:0]               det_pyr,
  input  logic signed [31:0]       det_accum,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [COORD_W-1:0]       rd_x,
  output logic [COORD_W-1:0]       rd_y,
  output logic [COORD_W-1:0]       rd_size,
  output logic signed [31:0]       rd_score,
  output logic [15:0]              det_count,
  output logic [15:0]              drop_count,
  output logic                     overflow,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t             state;
  state_t             state_next;
  logic               drain_cnt;

  logic               s1_valid;
  logic [31:0]        s1_x;
  logic [31:0]        s1_y;
  logic [3:0]         s1_pyr;
  logic signed [31:0] s1_score;
  logic [15:0]        s1_scale;

  logic               s2_valid;
  det_entry_t         s2_entry;

  det_entry_t         head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic               pop;
  logic               full_drop;
  logic               late_drop;
  logic               fifo_write;
  logic               enter_collect;
  logic [16:0]        drop_sum;

  function automatic logic [COORD_W-1:0] rescale(input logic [31:0] v, input logic [15:0] s);
    logic [47:0] p;
    p = (48'(v) * 48'(s)) >> FRAC_BITS;
    return (|(p >> COORD_W)) ? '1 : p[COORD_W-1:0];
  endfunction

  assign enter_collect = (state == IDLE) && frame_start;
  assign pop           = rd_valid && rd_ready;
  assign full_drop     = s2_valid && fifo_full && !pop;
  assign fifo_write    = s2_valid && !full_drop;
  assign late_drop     = det_valid && (state != COLLECT);
  assign drop_sum      = 17'(drop_count) + 17'(full_drop) + 17'(late_drop);

  // Stage 1: capture the raw detection.
  always_ff @(posedge clock) begin
    if (!reset) s1_valid <= 1'b0;
    else        s1_valid <= det_valid && (state == COLLECT);
  end

  always_ff @(posedge clock) begin
    s1_x     <= det_top_left[0];
    s1_y     <= det_top_left[1];
    s1_pyr   <= det_pyr;
    s1_score <= det_accum;
  end

  // NOTE: always_comb assigns a default first so no path leaves a latch behind.
  always_comb begin
    s1_scale = 16'(1 << FRAC_BITS);
    if (s1_pyr < 4'(NUM_PYRAMID)) s1_scale = SCALE_Q8[s1_pyr];
  end

  // Stage 2: rescale to source-image pixels; the FIFO takes it on the next edge.
  always_ff @(posedge clock) begin
    if (!reset) s2_valid <= 1'b0;
    else        s2_valid <= s1_valid;
  end

  always_ff @(posedge clock) begin
    s2_entry.x     <= rescale(s1_x, s1_scale);
    s2_entry.y     <= rescale(s1_y, s1_scale);
    s2_entry.size  <= rescale(32'(WIN_SIZE), s1_scale);
    s2_entry.score <= s1_score;
  end

  vj_det_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (det_entry_t)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (s2_valid),
    .wdata (s2_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rd_valid = !fifo_empty;
  assign rd_x     = rd_valid ? head.x     : '0;
  assign rd_y     = rd_valid ? head.y     : '0;
  assign rd_size  = rd_valid ? head.size  : '0;
  assign rd_score = rd_valid ? head.score : '0;

  // Frame counters clear on entry to COLLECT, which outranks same-edge drops.
  always_ff @(posedge clock) begin
    if (!reset || enter_collect) begin
      det_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (fifo_write && det_count != 16'hFFFF) det_count <= det_count + 1'b1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (full_drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Two DRAIN cycles flush S1 and S2 into the FIFO.
  always_ff @(posedge clock) begin
    if (!reset) drain_cnt <= 1'b0;
    else        drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = COLLECT;
      COLLECT: if (frame_end)   state_next = DRAIN;
      DRAIN:   if (drain_cnt)   state_next = DONE;
      DONE:    if (fifo_empty || (fifo_count == (AW+1)'(1) && pop)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_done = 1'b0;
    busy       = 1'b0;
    case (state)
      COLLECT, DRAIN: busy       = 1'b1;
      DONE:           frame_done = 1'b1;
      default:        ;
    endcase
  end

endmodule
